// File: rtl/alu_req_d.sv
// alu_req_d: initiator for the combinational alu_d block.
// Buffers operand commands in a FIFO, drives them onto alu_d one at a time,
// waits SETTLE cycles, captures all eight results and returns them in order.
// Optional: define ALU_CHECK_EN to build an internal reference model that
// flags result mismatches on rsp_err_d. Otherwise rsp_err_d is tied to 0.
module alu_req_d #(
   parameter int FIFO_DEPTH = 4,
   parameter int SETTLE     = 2,
   parameter int CNT_W      = 16
) (
   input  logic             clk_d,
   input  logic             rst_d,
   input  logic             cmd_valid_d,
   output logic             cmd_ready_d,
   input  logic [30:0]      cmd_a_d,
   input  logic [30:0]      cmd_b_d,
   input  logic [15:0]      cmd_l_d,
   input  logic [15:0]      cmd_m_d,
   output logic [30:0]      a_d,
   output logic [30:0]      b_d,
   output logic [15:0]      l_d,
   output logic [15:0]      m_d,
   output logic             alu_rst_d,
   input  logic [255:0]     alu_res_d,
   output logic             rsp_valid_d,
   input  logic             rsp_ready_d,
   output logic [255:0]     rsp_res_d,
   output logic             rsp_dz_d,
   output logic             rsp_err_d,
   output logic             busy_d,
   output logic [CNT_W-1:0] cmd_cnt_d
);

   localparam int AW   = $clog2(FIFO_DEPTH);
   localparam int WC_W = (SETTLE < 2) ? 1 : $clog2(SETTLE + 1);

   typedef struct packed {
      logic [30:0] a;
      logic [30:0] b;
      logic [15:0] l;
      logic [15:0] m;
   } cmd_t;

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

   cmd_t            fifo_mem [FIFO_DEPTH];
   logic [AW-1:0]   wr_ptr, rd_ptr;
   logic [AW:0]     count;
   logic            full, empty, push, pop;
   cmd_t            head;
   state_t          state, state_nxt;
   logic [WC_W-1:0] wcnt;
   logic            capture, done;
   logic [255:0]    res_cap;
   logic            err_cap;

   assign full        = (count == (AW+1)'(FIFO_DEPTH));
   assign empty       = (count == '0);
   assign push        = cmd_valid_d && !full;
   assign cmd_ready_d = !full;
   assign busy_d      = (state != S_IDLE) || !empty;
   assign head        = fifo_mem[rd_ptr];

   // FIFO storage: no reset needed, occupancy is tracked by count
   always_ff @(posedge clk_d) begin
      if (push) fifo_mem[wr_ptr] <= '{a: cmd_a_d, b: cmd_b_d, l: cmd_l_d, m: cmd_m_d};
   end

   // FIFO pointers and registered occupancy
   always_ff @(posedge clk_d) begin
      if (rst_d) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // FSM state register
   always_ff @(posedge clk_d) begin
      if (rst_d) state <= S_IDLE;
      else       state <= state_nxt;
   end

   // FSM next state: pop in IDLE or on a response handshake, capture at end of settle
   always_comb begin
      state_nxt = state;
      pop       = 1'b0;
      capture   = 1'b0;
      done      = 1'b0;
      case (state)
         S_IDLE: begin
            if (!empty) begin
               pop       = 1'b1;
               state_nxt = S_WAIT;
            end
         end
         S_WAIT: begin
            if (wcnt == WC_W'(1)) begin
               capture   = 1'b1;
               state_nxt = S_RESP;
            end
         end
         S_RESP: begin
            if (rsp_ready_d) begin
               done = 1'b1;
               if (!empty) begin
                  pop       = 1'b1;
                  state_nxt = S_WAIT;
               end else begin
                  state_nxt = S_IDLE;
               end
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // Quotient/remainder from alu_d are meaningless for m==0, so zero them
   always_comb begin
      res_cap = alu_res_d;
      if (m_d == '0) res_cap[159:96] = '0;
   end

`ifdef ALU_CHECK_EN
   logic [31:0] e_sum, e_dif, e_pro, e_quo, e_rem, e_and, e_or, e_xor;

   // Reference model evaluated from the operands currently driven to alu_d
   always_comb begin
      e_sum   = {1'b0, a_d} + {1'b0, b_d};
      e_dif   = {1'b0, a_d} - {1'b0, b_d};
      e_pro   = 32'(l_d) * 32'(m_d);
      e_quo   = '0;
      e_rem   = '0;
      if (m_d != '0) begin
         e_quo = 32'(l_d / m_d);
         e_rem = 32'(l_d % m_d);
      end
      e_and   = {1'b0, a_d & b_d};
      e_or    = {1'b0, a_d | b_d};
      e_xor   = {1'b0, a_d ^ b_d};
      err_cap = (alu_res_d[31:0]    != e_sum) || (alu_res_d[63:32]   != e_dif) ||
                (alu_res_d[95:64]   != e_pro) || (alu_res_d[191:160] != e_and) ||
                (alu_res_d[223:192] != e_or)  || (alu_res_d[255:224] != e_xor) ||
                ((m_d != '0) && ((alu_res_d[127:96] != e_quo) || (alu_res_d[159:128] != e_rem)));
   end
`else
   assign err_cap = 1'b0;
`endif

   // Operand drive, settle counter, response capture and completion count
   always_ff @(posedge clk_d) begin
      if (rst_d) begin
         a_d         <= '0;
         b_d         <= '0;
         l_d         <= '0;
         m_d         <= '0;
         wcnt        <= '0;
         rsp_valid_d <= 1'b0;
         rsp_res_d   <= '0;
         rsp_dz_d    <= 1'b0;
         rsp_err_d   <= 1'b0;
         cmd_cnt_d   <= '0;
      end else begin
         if (pop) begin
            a_d  <= head.a;
            b_d  <= head.b;
            l_d  <= head.l;
            m_d  <= head.m;
            wcnt <= WC_W'(SETTLE);
         end else if (state == S_WAIT) begin
            wcnt <= wcnt - 1'b1;
         end
         if (capture) begin
            rsp_valid_d <= 1'b1;
            rsp_res_d   <= res_cap;
            rsp_dz_d    <= (m_d == '0);
            rsp_err_d   <= err_cap;
         end else if (done) begin
            rsp_valid_d <= 1'b0;
         end
         if (done) cmd_cnt_d <= cmd_cnt_d + 1'b1;
      end
   end

   // alu_d reset follows ours by one cycle
   always_ff @(posedge clk_d) begin
      alu_rst_d <= rst_d;
   end

endmodule

// File: tb/tb_alu_req_d.sv
// Scoreboard bench for alu_req_d with a behavioural alu_d stand-in.
module tb_alu_req_d;
   localparam int CNT_W = 16;

   logic             clk_d = 1'b0;
   logic             rst_d;
   logic             cmd_valid_d, cmd_ready_d;
   logic [30:0]      cmd_a_d, cmd_b_d, a_d, b_d;
   logic [15:0]      cmd_l_d, cmd_m_d, l_d, m_d;
   logic             alu_rst_d;
   logic [255:0]     alu_res_d, rsp_res_d;
   logic             rsp_valid_d, rsp_ready_d, rsp_dz_d, rsp_err_d, busy_d;
   logic [CNT_W-1:0] cmd_cnt_d;
   logic             force_sum0 = 1'b0;

   always #5 clk_d = ~clk_d;

   alu_req_d #(.FIFO_DEPTH(4), .SETTLE(2), .CNT_W(CNT_W)) dut (
      .clk_d(clk_d), .rst_d(rst_d), .cmd_valid_d(cmd_valid_d), .cmd_ready_d(cmd_ready_d),
      .cmd_a_d(cmd_a_d), .cmd_b_d(cmd_b_d), .cmd_l_d(cmd_l_d), .cmd_m_d(cmd_m_d),
      .a_d(a_d), .b_d(b_d), .l_d(l_d), .m_d(m_d), .alu_rst_d(alu_rst_d),
      .alu_res_d(alu_res_d), .rsp_valid_d(rsp_valid_d), .rsp_ready_d(rsp_ready_d),
      .rsp_res_d(rsp_res_d), .rsp_dz_d(rsp_dz_d), .rsp_err_d(rsp_err_d),
      .busy_d(busy_d), .cmd_cnt_d(cmd_cnt_d));

   // alu_d stand-in; divide by zero returns all-ones quotient and l as remainder
   logic [31:0] m_sum, m_dif, m_pro, m_quo, m_rem;
   always_comb begin
      m_sum = force_sum0 ? 32'h0 : ({1'b0, a_d} + {1'b0, b_d});
      m_dif = {1'b0, a_d} - {1'b0, b_d};
      m_pro = 32'(l_d) * 32'(m_d);
      m_quo = 32'hFFFF_FFFF;
      m_rem = 32'(l_d);
      if (m_d != 16'h0) begin
         m_quo = 32'(l_d / m_d);
         m_rem = 32'(l_d % m_d);
      end
      alu_res_d = {{1'b0, a_d ^ b_d}, {1'b0, a_d | b_d}, {1'b0, a_d & b_d},
                   m_rem, m_quo, m_pro, m_dif, m_sum};
   end

   typedef struct {
      logic [255:0] res;
      logic         dz;
      logic         err;
   } exp_t;

   exp_t sbq[$];
   exp_t mon_e;
   int   checks = 0;
   int   errors = 0;

   function automatic logic [255:0] pack(input logic [31:0] s, d, p, q, r, an, o, x);
      return {x, o, an, r, q, p, d, s};
   endfunction

   function automatic exp_t mk(input logic [255:0] res, input logic dz, input logic err);
      exp_t e;
      e.res = res; e.dz = dz; e.err = err;
      return e;
   endfunction

   task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got=%0h want=%0h", nm, act, exp);
      end
   endtask

   // Monitor: compare every accepted response against the scoreboard head
   always @(negedge clk_d) begin
      if (rst_d === 1'b0 && rsp_valid_d === 1'b1 && rsp_ready_d === 1'b1) begin
         if (sbq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_rsp got=%0h want=none", rsp_res_d);
         end else begin
            mon_e = sbq.pop_front();
            chk("rsp_res", rsp_res_d, mon_e.res);
            chk("rsp_dz", 256'(rsp_dz_d), 256'(mon_e.dz));
            chk("rsp_err", 256'(rsp_err_d), 256'(mon_e.err));
         end
      end
   end

   task automatic tick;
      @(posedge clk_d);
      #1;
   endtask

   task automatic send(input logic [30:0] a, b, input logic [15:0] l, m,
                       input exp_t e, input bit track);
      bit done = 1'b0;
      cmd_a_d = a; cmd_b_d = b; cmd_l_d = l; cmd_m_d = m;
      cmd_valid_d = 1'b1;
      for (int i = 0; i < 100 && !done; i++) begin
         @(negedge clk_d);
         if (cmd_ready_d) begin
            if (track) sbq.push_back(e);
            done = 1'b1;
         end
         tick();
      end
      cmd_valid_d = 1'b0;
      if (!done) begin
         checks++;
         errors++;
         $display("FAIL send_timeout got=not_ready want=accepted");
      end
   endtask

   task automatic drain;
      for (int i = 0; i < 200 && sbq.size() != 0; i++) tick();
      tick();
      chk("drain_empty", 256'(sbq.size()), 256'(0));
   endtask

   function automatic exp_t burst_exp(input int i);
      logic [31:0] a, b, l, m;
      a = 32'(i + 1) * 32'h111; b = 32'(i + 2); l = 32'(1000 + i); m = 32'(3 + i);
      return mk(pack(a + b, a - b, l * m, l / m, l % m, a & b, a | b, a ^ b), 1'b0, 1'b0);
   endfunction

   exp_t e1, e2, e3, e4;
   int   accepted;
   bit   seen;
   bit   err_exp;

   initial begin
`ifdef ALU_CHECK_EN
      err_exp = 1'b1;
`else
      err_exp = 1'b0;
`endif
      e1 = mk(pack(32'd8, 32'd2, 32'd700, 32'd14, 32'd2, 32'd1, 32'd7, 32'd6), 1'b0, 1'b0);
      e2 = mk(pack(32'h8000_0000, 32'h7FFF_FFFE, 32'd6, 32'd1, 32'd1, 32'd1,
                   32'h7FFF_FFFF, 32'h7FFF_FFFE), 1'b0, 1'b0);
      e3 = mk(pack(32'd8, 32'hFFFF_FFFE, 32'd0, 32'd0, 32'd0, 32'd1, 32'd7, 32'd6), 1'b1, 1'b0);
      e4 = mk(pack(32'd0, 32'd2, 32'd700, 32'd14, 32'd2, 32'd1, 32'd7, 32'd6), 1'b0, err_exp);

      rst_d = 1'b1; cmd_valid_d = 1'b0; rsp_ready_d = 1'b0;
      cmd_a_d = '0; cmd_b_d = '0; cmd_l_d = '0; cmd_m_d = '0;
      repeat (3) @(posedge clk_d);
      #1;
      chk("rst_rsp_valid", 256'(rsp_valid_d), 256'(0));
      chk("rst_cmd_ready", 256'(cmd_ready_d), 256'(1));
      chk("rst_alu_rst", 256'(alu_rst_d), 256'(1));
      chk("rst_busy", 256'(busy_d), 256'(0));
      chk("rst_cnt", 256'(cmd_cnt_d), 256'(0));
      chk("rst_ops", {a_d, b_d, l_d, m_d}, 256'(0));
      chk("rst_rsp", {rsp_res_d[253:0], rsp_dz_d, rsp_err_d}, 256'(0));
      rst_d = 1'b0;
      @(negedge clk_d);
      chk("alu_rst_hold", 256'(alu_rst_d), 256'(1));
      tick();
      chk("alu_rst_fall", 256'(alu_rst_d), 256'(0));

      // Latency and hold: accept at E, operands at E+1, valid at E+3
      cmd_a_d = 31'd5; cmd_b_d = 31'd3; cmd_l_d = 16'd100; cmd_m_d = 16'd7;
      cmd_valid_d = 1'b1;
      sbq.push_back(e1);
      tick();
      cmd_valid_d = 1'b0;
      chk("ops_not_yet", 256'(a_d), 256'(0));
      tick();
      chk("ops_driven", {a_d, b_d, l_d, m_d}, 256'({31'd5, 31'd3, 16'd100, 16'd7}));
      chk("valid_e1", 256'(rsp_valid_d), 256'(0));
      tick();
      chk("valid_e2", 256'(rsp_valid_d), 256'(0));
      tick();
      chk("valid_e3", 256'(rsp_valid_d), 256'(1));
      chk("busy_resp", 256'(busy_d), 256'(1));
      tick();
      tick();
      chk("hold_valid", 256'(rsp_valid_d), 256'(1));
      chk("hold_res", rsp_res_d, e1.res);
      rsp_ready_d = 1'b1;
      tick();
      chk("valid_clear", 256'(rsp_valid_d), 256'(0));
      chk("cnt_1", 256'(cmd_cnt_d), 256'(1));

      send(31'h7FFF_FFFF, 31'd1, 16'd3, 16'd2, e2, 1'b1);
      send(31'd3, 31'd5, 16'd9, 16'd0, e3, 1'b1);
      drain();
      chk("cnt_3", 256'(cmd_cnt_d), 256'(3));
      chk("ops_hold", {a_d, b_d, l_d, m_d}, 256'({31'd3, 31'd5, 16'd9, 16'd0}));

      force_sum0 = 1'b1;
      send(31'd5, 31'd3, 16'd100, 16'd7, e4, 1'b1);
      drain();
      force_sum0 = 1'b0;

      // Burst with response port stalled
      rst_d = 1'b1; tick(); tick(); rst_d = 1'b0;
      chk("cnt_cleared", 256'(cmd_cnt_d), 256'(0));
      rsp_ready_d = 1'b0;
      accepted = 0;
      for (int i = 0; i < 6; i++) begin
         cmd_a_d = 31'((i + 1) * 'h111); cmd_b_d = 31'(i + 2);
         cmd_l_d = 16'(1000 + i);        cmd_m_d = 16'(3 + i);
         cmd_valid_d = 1'b1;
         @(negedge clk_d);
         if (cmd_ready_d) begin
            accepted++;
            sbq.push_back(burst_exp(i));
         end
         tick();
      end
      cmd_valid_d = 1'b0;
      chk("burst_accepted", 256'(accepted), 256'(5));
      chk("burst_full", 256'(cmd_ready_d), 256'(0));
      rsp_ready_d = 1'b1;
      send(31'(6 * 'h111), 31'd7, 16'd1005, 16'd8, burst_exp(5), 1'b1);
      drain();
      chk("cnt_6", 256'(cmd_cnt_d), 256'(6));
      chk("idle_busy", 256'(busy_d), 256'(0));

      // Reset during WAIT drops the transaction
      send(31'd11, 31'd22, 16'd33, 16'd4, e1, 1'b0);
      tick();
      rst_d = 1'b1;
      tick();
      rst_d = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 8; i++) begin
         tick();
         if (rsp_valid_d) seen = 1'b1;
      end
      chk("midrst_no_rsp", 256'(seen), 256'(0));
      chk("midrst_busy", 256'(busy_d), 256'(0));
      chk("midrst_cnt", 256'(cmd_cnt_d), 256'(0));
      chk("midrst_ready", 256'(cmd_ready_d), 256'(1));
      chk("sb_empty", 256'(sbq.size()), 256'(0));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout want=finish");
      $fatal(1);
   end

endmodule
